// File: rtl/test_harness_pkg.sv
// Shared types and helpers for the analyzer-tap serializer.
package test_harness_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   localparam int DROP_W = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/th_rate_div.sv
// Chunk-rate divider: counts DIV cycles per chunk, flags chunk boundaries.
module th_rate_div #(
   parameter int DIV = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic adv_o,
   output logic first_o
);

   localparam logic [7:0] LAST = 8'(DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      adv_o = en_i && (cnt_q == LAST);
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = adv_o ? 8'd0 : cnt_q + 8'd1;
      end
   end

   // first_o describes the cycle that follows this edge
   assign first_o = (cnt_d == 8'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/test_harness_serializer.sv
// Captures one word per handshake and replays it as CHUNK_W-wide
// chunks, LSB first, with strobe, frame marker and drop counter.
module test_harness_serializer
   import test_harness_pkg::*;
#(
   parameter int DATA_W  = 48,
   parameter int CHUNK_W = 8,
   parameter int DIV     = 1,
   parameter int GAP     = 2
) (
   input  logic                CLK_1MHZ,
   input  logic                RESET,
   input  logic [DATA_W-1:0]   DATA_IN,
   input  logic                DATA_VALID,
   output logic                DATA_READY,
   output logic [CHUNK_W-1:0]  D_OUT,
   output logic                D_STROBE,
   output logic                FRAME_START,
   output logic                BUSY,
   output logic [DROP_W-1:0]   DROP_CNT
);

   localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
   localparam int PAD_W  = NCHUNK * CHUNK_W;
   localparam int CIW    = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
   localparam int GW     = (clog2(GAP + 1) < 1) ? 1 : clog2(GAP + 1);
   localparam logic [CIW-1:0] CH_LAST  = CIW'(NCHUNK - 1);
   localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   state_e              state_q, state_d;
   logic [PAD_W-1:0]    buf_q, buf_d;
   logic [CIW-1:0]      chunk_q, chunk_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [DROP_W-1:0]   drop_q, drop_d;
   logic [CHUNK_W-1:0]  dout_q, dout_d;
   logic                strb_q, strb_d;
   logic                fs_q, fs_d;
   logic                busy_q, busy_d;
   logic                rdy_q, rdy_d;

   logic [PAD_W-1:0]    pad;
   logic                xfer;
   logic                adv;
   logic                first;

   always_comb begin
      pad = '0;
      pad[DATA_W-1:0] = DATA_IN;
   end

   assign xfer = DATA_VALID && rdy_q;

   th_rate_div #(
      .DIV (DIV)
   ) u_div (
      .clk_i   (CLK_1MHZ),
      .rst_i   (RESET),
      .clr_i   (xfer),
      .en_i    (state_q == ST_SEND),
      .adv_o   (adv),
      .first_o (first)
   );

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      chunk_d = chunk_q;
      gap_d   = gap_q;
      drop_d  = drop_q;
      unique case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               state_d = ST_SEND;
               buf_d   = pad;
               chunk_d = '0;
            end
         end
         ST_SEND: begin
            if (adv) begin
               if (chunk_q == CH_LAST) begin
                  gap_d   = '0;
                  state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
               end else begin
                  buf_d   = buf_q >> CHUNK_W;
                  chunk_d = chunk_q + CIW'(1);
               end
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) state_d = ST_IDLE;
            else                   gap_d   = gap_q + GW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      if (DATA_VALID && !rdy_q && drop_q != '1) begin
         drop_d = drop_q + DROP_W'(1);
      end
      // outputs are registered from the next-state view
      dout_d = (state_d == ST_SEND) ? buf_d[CHUNK_W-1:0] : '0;
      strb_d = (state_d == ST_SEND) && first;
      fs_d   = strb_d && (chunk_d == '0);
      busy_d = (state_d != ST_IDLE);
      rdy_d  = (state_d == ST_IDLE);
   end

   always_ff @(posedge CLK_1MHZ) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         buf_q   <= '0;
         chunk_q <= '0;
         gap_q   <= '0;
         drop_q  <= '0;
         dout_q  <= '0;
         strb_q  <= 1'b0;
         fs_q    <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         chunk_q <= chunk_d;
         gap_q   <= gap_d;
         drop_q  <= drop_d;
         dout_q  <= dout_d;
         strb_q  <= strb_d;
         fs_q    <= fs_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
      end
   end

   assign DATA_READY  = rdy_q;
   assign D_OUT       = dout_q;
   assign D_STROBE    = strb_q;
   assign FRAME_START = fs_q;
   assign BUSY        = busy_q;
   assign DROP_CNT    = drop_q;

endmodule

// File: tb/tb_test_harness_serializer.sv
// Directed bench for test_harness_serializer in three configurations.
module tb_test_harness_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // a: defaults, b: DATA_W=20 DIV=3, c: GAP=0
   logic        rst_a, vld_a, rdy_a, strb_a, fs_a, busy_a;
   logic [47:0] din_a;
   logic [7:0]  dout_a, drop_a;
   logic        rst_b, vld_b, rdy_b, strb_b, fs_b, busy_b;
   logic [19:0] din_b;
   logic [7:0]  dout_b, drop_b;
   logic        rst_c, vld_c, rdy_c, strb_c, fs_c, busy_c;
   logic [47:0] din_c;
   logic [7:0]  dout_c, drop_c;

   test_harness_serializer dut_a (
      .CLK_1MHZ(clk), .RESET(rst_a), .DATA_IN(din_a),
      .DATA_VALID(vld_a), .DATA_READY(rdy_a), .D_OUT(dout_a),
      .D_STROBE(strb_a), .FRAME_START(fs_a), .BUSY(busy_a),
      .DROP_CNT(drop_a)
   );

   test_harness_serializer #(.DATA_W(20), .DIV(3)) dut_b (
      .CLK_1MHZ(clk), .RESET(rst_b), .DATA_IN(din_b),
      .DATA_VALID(vld_b), .DATA_READY(rdy_b), .D_OUT(dout_b),
      .D_STROBE(strb_b), .FRAME_START(fs_b), .BUSY(busy_b),
      .DROP_CNT(drop_b)
   );

   test_harness_serializer #(.GAP(0)) dut_c (
      .CLK_1MHZ(clk), .RESET(rst_c), .DATA_IN(din_c),
      .DATA_VALID(vld_c), .DATA_READY(rdy_c), .D_OUT(dout_c),
      .D_STROBE(strb_c), .FRAME_START(fs_c), .BUSY(busy_c),
      .DROP_CNT(drop_c)
   );

   task automatic test_reset();
      rst_a = 1; rst_b = 1; rst_c = 1;
      vld_a = 0; vld_b = 0; vld_c = 0;
      din_a = '0; din_b = '0; din_c = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({dout_a, strb_a, fs_a, busy_a, rdy_a, drop_a} !==
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL reset_a: got %h/%b%b%b%b/%h want 00/0001/00",
                  dout_a, strb_a, fs_a, busy_a, rdy_a, drop_a);
      end
      checks++;
      if ({dout_b, busy_b, rdy_b, dout_c, busy_c, rdy_c} !==
          {8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_bc: got b %h %b%b c %h %b%b want 00 01",
                  dout_b, busy_b, rdy_b, dout_c, busy_c, rdy_c);
      end
      rst_a = 0; rst_b = 0; rst_c = 0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      din_a = 48'h0605_0403_0201;
      vld_a = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vld_a = 0;
         din_a = '1;
         checks++;
         if ({dout_a, strb_a, fs_a, busy_a} !==
             {8'(i + 1), 1'b1, (i == 0), 1'b1}) begin
            errors++;
            $display("FAIL basic_chunk%0d: got %h s%b f%b b%b want %h s1 f%b b1",
                     i, dout_a, strb_a, fs_a, busy_a, 8'(i + 1), (i == 0));
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({dout_a, strb_a, fs_a, busy_a, rdy_a} !==
             {8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_gap%0d: got %h s%b f%b b%b r%b want 00 s0 f0 b1 r0",
                     i, dout_a, strb_a, fs_a, busy_a, rdy_a);
         end
      end
      @(negedge clk);
      checks++;
      if ({rdy_a, busy_a, dout_a} !== {1'b1, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL basic_idle: got r%b b%b %h want r1 b0 00",
                  rdy_a, busy_a, dout_a);
      end
   endtask

   task automatic test_div_pad();
      logic [7:0] ch [3];
      ch[0] = 8'hDE; ch[1] = 8'hBC; ch[2] = 8'h0A;
      din_b = 20'hABCDE;
      vld_b = 1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         vld_b = 0;
         checks++;
         if ({dout_b, strb_b, fs_b, busy_b} !==
             {ch[i / 3], (i % 3 == 0), (i == 0), 1'b1}) begin
            errors++;
            $display("FAIL divpad_cyc%0d: got %h s%b f%b b%b want %h s%b f%b b1",
                     i, dout_b, strb_b, fs_b, busy_b, ch[i / 3],
                     (i % 3 == 0), (i == 0));
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({dout_b, strb_b, busy_b, rdy_b} !==
             {8'h00, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL divpad_gap%0d: got %h s%b b%b r%b want 00 s0 b1 r0",
                     i, dout_b, strb_b, busy_b, rdy_b);
         end
      end
      @(negedge clk);
      checks++;
      if ({rdy_b, busy_b} !== 2'b10) begin
         errors++;
         $display("FAIL divpad_idle: got r%b b%b want r1 b0", rdy_b, busy_b);
      end
   endtask

   task automatic test_drop();
      int exp_drop;
      int p;
      rst_a = 1;
      @(negedge clk);
      rst_a = 0;
      din_a = 48'h1234_5678_9ABC;
      vld_a = 1;
      exp_drop = 0;
      for (int c = 1; c <= 360; c++) begin
         @(negedge clk);
         p = (c - 1) % 9;
         checks++;
         if ({fs_a, rdy_a, drop_a} !== {(p == 0), (p == 8), 8'(exp_drop)}) begin
            errors++;
            $display("FAIL drop_cyc%0d: got f%b r%b cnt %0d want f%b r%b cnt %0d",
                     c, fs_a, rdy_a, drop_a, (p == 0), (p == 8), exp_drop);
         end
         if (p != 8 && exp_drop < 255) exp_drop++;
      end
      vld_a = 0;
      checks++;
      if (drop_a !== 8'd255) begin
         errors++;
         $display("FAIL drop_sat: got %0d want 255", drop_a);
      end
   endtask

   task automatic test_no_repeat();
      int n_fs;
      int n_nz;
      rst_a = 1;
      @(negedge clk);
      rst_a = 0;
      checks++;
      if (drop_a !== 8'd0) begin
         errors++;
         $display("FAIL norep_dropclr: got %0d want 0", drop_a);
      end
      din_a = 48'hFFEE_DDCC_BBAA;
      vld_a = 1;
      n_fs = 0;
      n_nz = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         vld_a = 0;
         if (fs_a) n_fs++;
         if (i >= 6 && dout_a != 8'h00) n_nz++;
      end
      checks++;
      if (n_fs !== 1) begin
         errors++;
         $display("FAIL norep_frames: got %0d want 1", n_fs);
      end
      checks++;
      if (n_nz !== 0) begin
         errors++;
         $display("FAIL norep_dout: got %0d nonzero cycles want 0", n_nz);
      end
      checks++;
      if ({busy_a, rdy_a} !== 2'b01) begin
         errors++;
         $display("FAIL norep_idle: got b%b r%b want b0 r1", busy_a, rdy_a);
      end
   endtask

   task automatic test_reset_mid();
      din_a = 48'h6655_4433_2211;
      vld_a = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vld_a = 0;
      end
      checks++;
      if (dout_a !== 8'h44) begin
         errors++;
         $display("FAIL rstmid_chunk3: got %h want 44", dout_a);
      end
      rst_a = 1;
      @(negedge clk);
      checks++;
      if ({dout_a, strb_a, fs_a, busy_a, rdy_a, drop_a} !==
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL rstmid_vals: got %h/%b%b%b%b/%h want 00/0001/00",
                  dout_a, strb_a, fs_a, busy_a, rdy_a, drop_a);
      end
      rst_a = 0;
      din_a = 48'hCCBB_AA99_8877;
      vld_a = 1;
      @(negedge clk);
      vld_a = 0;
      checks++;
      if ({dout_a, strb_a, fs_a} !== {8'h77, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL rstmid_restart: got %h s%b f%b want 77 s1 f1",
                  dout_a, strb_a, fs_a);
      end
      @(negedge clk);
      checks++;
      if ({dout_a, fs_a} !== {8'h88, 1'b0}) begin
         errors++;
         $display("FAIL rstmid_next: got %h f%b want 88 f0", dout_a, fs_a);
      end
   endtask

   task automatic test_back_to_back();
      int n_x;
      int n_fs;
      int t1;
      int t2;
      logic [7:0] d2;
      n_x = 0; n_fs = 0; t1 = -1; t2 = -1; d2 = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (fs_c) begin
            n_fs++;
            if (n_fs == 1) t1 = c;
            if (n_fs == 2) begin t2 = c; d2 = dout_c; end
         end
         if (rdy_c && n_x < 2) begin
            vld_c = 1;
            din_c = (n_x == 0) ? 48'h0000_0000_0011 : 48'h0000_0000_0055;
            n_x++;
         end else begin
            vld_c = 0;
         end
      end
      checks++;
      if (n_fs !== 2) begin
         errors++;
         $display("FAIL b2b_frames: got %0d want 2", n_fs);
      end
      checks++;
      if (t2 - t1 !== 7) begin
         errors++;
         $display("FAIL b2b_period: got %0d want 7", t2 - t1);
      end
      checks++;
      if ({d2, drop_c} !== {8'h55, 8'h00}) begin
         errors++;
         $display("FAIL b2b_data: got %h drop %0d want 55 drop 0", d2, drop_c);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_pad();
      test_drop();
      test_no_repeat();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/test_harness_serializer.md
Name: test_harness_serializer

Overview:
- Parametrised successor to the fixed 48-bit/8-lane logic-analyzer tap.
- Captures one word per valid/ready handshake and presents it on CHUNK_W analyzer lanes, LSB chunk first, at a programmable chunk rate.
- Drives a chunk strobe and a frame marker, so the analyzer can trigger and align.
- Sends each captured word exactly once (no re-sending of stale data) and counts words dropped while busy.

Parameters:
- DATA_W, 48: width of the captured word.
- CHUNK_W, 8: analyzer lane count (chunk width).
- DIV, 1: CLK_1MHZ cycles each chunk is held on D_OUT; legal range 1..255.
- GAP, 2: idle cycles (D_OUT=0) inserted after the last chunk of a frame; 0 is legal.
- NCHUNK, derived as ceil(DATA_W/CHUNK_W): chunks per frame.

Ports:
- CLK_1MHZ  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- DATA_IN  in  DATA_W  word to capture.
- DATA_VALID  in  1  DATA_IN is valid this cycle.
- DATA_READY  out  1  block can accept a word this cycle.
- D_OUT  out  CHUNK_W  analyzer lanes.
- D_STROBE  out  1  high for the first cycle of every chunk.
- FRAME_START  out  1  high for the first cycle of chunk 0 only.
- BUSY  out  1  a frame is being sent or the gap is running.
- DROP_CNT  out  8  count of DATA_VALID cycles refused (DATA_READY=0); saturates at 255.

Behaviour:
- Clock and reset: one clock, CLK_1MHZ. Reset is synchronous and active-high on RESET.
- Reset values:
  - State IDLE.
  - D_OUT=0, D_STROBE=0, FRAME_START=0, BUSY=0.
  - DATA_READY=1, DROP_CNT=0.
  - Shift buffer and counters cleared.
- Reset mid-frame: aborts the frame. The next cycle shows reset values and nothing is partially resumed.
- Handshake:
  - A transfer occurs on a rising edge where DATA_VALID=1 and DATA_READY=1.
  - DATA_READY=1 only in IDLE.
  - DATA_VALID=1 with DATA_READY=0 increments DROP_CNT by 1 per cycle, saturating at 255.
  - A refused word is never queued.
- Padding: the captured word is zero-extended to NCHUNK*CHUNK_W bits.
- State IDLE:
  - D_OUT=0, BUSY=0.
  - On a transfer: load the buffer, then go to SEND with chunk index 0 and divider count 0.
- State SEND:
  - Latency: the cycle after the transfer, D_OUT = buffer[CHUNK_W-1:0], D_STROBE=1, FRAME_START=1, BUSY=1.
  - Each chunk is held for exactly DIV cycles. D_STROBE is high only in the first of those cycles; FRAME_START only for chunk 0.
  - After DIV cycles, shift the buffer right by CHUNK_W and increment the chunk index.
  - After chunk NCHUNK-1 has been held for DIV cycles:
    - if GAP>0, go to GAP;
    - if GAP=0, go to IDLE.
- State GAP:
  - D_OUT=0, strobes low, BUSY=1, DATA_READY=0 for GAP cycles, then IDLE.
- Back-to-back frames:
  - Earliest next transfer is the first IDLE cycle.
  - With GAP=0, the frame period is NCHUNK*DIV+1 cycles (one IDLE handshake cycle between frames).
- Counter widths:
  - Chunk index: clog2(NCHUNK) bits, minimum 1.
  - Divider: 8 bits.
  - Gap counter: clog2(GAP+1) bits, minimum 1.
- Corner cases:
  - NCHUNK=1: a single chunk per frame; FRAME_START and D_STROBE coincide.
  - DATA_W < CHUNK_W: upper lanes read 0.
- DATA_IN is sampled only at transfer; changes during SEND have no effect.
- All outputs are registered.

Decomposition:
- Shared package test_harness_pkg holds:
  - state encoding (IDLE=2'd0, SEND=2'd1, GAP=2'd2);
  - a clog2 function;
  - the DROP_CNT width constant (8).
- One natural sub-module, th_rate_div: the DIV-cycle counter producing a chunk-advance pulse and a first-cycle flag.
- The top module holds the FSM, the shift buffer and the drop counter.

Test Plan:
- Basic frame, defaults:
  - Stimulus: reset, then transfer DATA_IN=48'h0605_0403_0201.
  - Response: D_OUT = 01,02,03,04,05,06 on consecutive cycles; D_STROBE high each cycle; FRAME_START only with 01.
  - Then 2 cycles of 00 with BUSY=1, then DATA_READY=1.
- Rate divider and padding:
  - Stimulus: DIV=3, DATA_W=20, CHUNK_W=8, transfer 20'hABCDE.
  - Response: chunks DE, BC, 0A, each held 3 cycles, D_STROBE on the first cycle of each; exactly 3 chunks.
- Drop counting:
  - Stimulus: hold DATA_VALID=1 continuously with defaults.
  - Response: one frame per 9 cycles (6 SEND, 2 GAP, 1 IDLE). DROP_CNT rises by 8 per frame and saturates at 255, with no wrap.
- No repeat:
  - Stimulus: one transfer, then DATA_VALID=0 for 50 cycles.
  - Response: exactly one FRAME_START; D_OUT=0 after the gap.
- Reset mid-frame:
  - Stimulus: assert RESET during chunk 3.
  - Response: the next cycle shows all outputs at reset values and DATA_READY=1.
  - A new transfer restarts at chunk 0 with its own data.
- GAP=0 back-to-back:
  - Stimulus: two transfers, each on the first cycle DATA_READY=1.
  - Response: frame period is 7 cycles; the second FRAME_START comes 7 cycles after the first.
